// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 pipeline control slice: icodes, status codes,
// register sentinel and control-state encodings.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } ctrl_state_t;

  function automatic logic stat_is_fault(input logic [3:0] stat);
    return (stat == STAT_ADR) || (stat == STAT_INS);
  endfunction

endpackage

// File: rtl/y86_hazard_detect.sv
// Combinational hazard terms for the Y86-64 pipeline: load/use, ret in flight,
// jXX mispredict and exception in memory/writeback.
module y86_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [3:0] m_stat,
  input  logic [3:0] W_stat,
  output logic       lu,
  output logic       ret,
  output logic       misp,
  output logic       exc
);

  // Hazard term evaluation; a dstM of REG_NONE never matches a source.
  always_comb begin
    lu   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
           (E_dstM != REG_NONE) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    misp = (E_icode == I_JXX) && !e_Cnd;
    exc  = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);
  end

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Pipeline control for the 5-stage Y86-64 pipeline: run/halt FSM, per-stage
// stall/bubble muxing, set_cc and RUN-time performance counters.
module y86_pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, instr_q, instr_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             lu, ret, misp, exc;

  y86_hazard_detect u_hazard (
    .D_icode (D_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_icode (E_icode),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .M_icode (M_icode),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .lu      (lu),
    .ret     (ret),
    .misp    (misp),
    .exc     (exc)
  );

  // Run/halt next-state: HALTED and FAULT are left only through rst_n.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (W_stat == STAT_HLT)        state_d = ST_HALTED;
        else if (stat_is_fault(W_stat)) state_d = ST_FAULT;
        else                           state_d = ST_RUN;
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  // Stage controls: hazard-driven in RUN, frozen pipeline otherwise.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b1;
    W_stall  = 1'b1;
    set_cc   = 1'b0;
    if (state_q == ST_RUN) begin
      F_stall  = lu | ret;
      D_stall  = lu;
      D_bubble = misp | (ret & !lu);
      E_bubble = misp | lu;
      M_bubble = exc;
      W_stall  = (W_stat != STAT_AOK);
      set_cc   = (E_icode == I_OPQ) && !exc;
    end else begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      set_cc   = 1'b0;
    end
  end

  // Counter next-state: cleared when start is accepted, advance only in RUN.
  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if ((state_q == ST_IDLE) && start) begin
      cycle_d = '0;
      instr_d = '0;
      stall_d = '0;
      flush_d = '0;
    end else if (state_q == ST_RUN) begin
      cycle_d = cycle_q + CNT_ONE;
      if ((W_stat == STAT_AOK) && (W_icode != I_NOP)) instr_d = instr_q + CNT_ONE;
      else                                            instr_d = instr_q;
      if (lu) stall_d = stall_q + CNT_ONE;
      else    stall_d = stall_q;
      if (misp) flush_d = flush_q + CNT_ONE;
      else      flush_d = flush_q;
    end else begin
      cycle_d = cycle_q;
    end
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cycle_q <= '0;
      instr_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign ctrl_state = state_q;
  assign cycle_cnt  = cycle_q;
  assign instr_cnt  = instr_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Directed scoreboard bench for y86_pipe_ctrl: expectations are queued per step
// and popped/asserted at the falling edge, away from the active clock edge.
module tb_y86_pipe_ctrl;
  import y86_pkg::*;

  localparam int SEL_CTL = 0, SEL_ST = 1, SEL_CYC = 2, SEL_INS = 3, SEL_STL = 4, SEL_FLS = 5;
  localparam int SEL_S_CYC = 6, SEL_S_ST = 7, SEL_S_CTL = 8, SEL_S_CNT = 9;
  localparam logic [6:0] FREEZE = 7'b1100110;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } entry_t;

  entry_t      sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] n_run = 32'd0;

  logic clk = 1'b0;
  logic rst_n, rst2_n, start, start2, e_Cnd;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_icode, W_stat;

  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic [1:0]  ctrl_state;
  logic [31:0] cycle_cnt, instr_cnt, stall_cnt, flush_cnt;

  logic s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_set_cc;
  logic [1:0] s_ctrl_state;
  logic [3:0] s_cycle_cnt, s_instr_cnt, s_stall_cnt, s_flush_cnt;

  y86_pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .ctrl_state(ctrl_state),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  y86_pipe_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble), .E_bubble(s_E_bubble),
    .M_bubble(s_M_bubble), .W_stall(s_W_stall), .set_cc(s_set_cc), .ctrl_state(s_ctrl_state),
    .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    entry_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sample();
    entry_t      e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_CTL:   obs = {25'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
        SEL_ST:    obs = {30'd0, ctrl_state};
        SEL_CYC:   obs = cycle_cnt;
        SEL_INS:   obs = instr_cnt;
        SEL_STL:   obs = stall_cnt;
        SEL_FLS:   obs = flush_cnt;
        SEL_S_CYC: obs = {28'd0, s_cycle_cnt};
        SEL_S_ST:  obs = {30'd0, s_ctrl_state};
        SEL_S_CTL: obs = {25'd0, s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_set_cc};
        SEL_S_CNT: obs = {20'd0, s_instr_cnt, s_stall_cnt, s_flush_cnt};
        default:   obs = 32'hDEAD_BEEF;
      endcase
      n_total++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  // One clock step: queue control/state/cycle expectations, check at negedge.
  task automatic cyc(input string tag, input logic [6:0] ctl, input logic [1:0] st);
    push({tag, "_ctl"}, SEL_CTL, {25'd0, ctl});
    push({tag, "_state"}, SEL_ST, {30'd0, st});
    push({tag, "_cycle"}, SEL_CYC, n_run);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (st == 2'd1) n_run++;
  endtask

  task automatic quiet();
    D_icode = I_NOP; d_srcA = REG_NONE; d_srcB = REG_NONE;
    E_icode = I_NOP; E_dstM = REG_NONE; e_Cnd = 1'b1;
    M_icode = I_NOP; m_stat = STAT_AOK; W_icode = I_NOP; W_stat = STAT_AOK;
  endtask

  task automatic reset_mid(input string tag);
    rst_n = 1'b0;
    #2;
    push({tag, "_ctl"}, SEL_CTL, {25'd0, FREEZE});
    push({tag, "_state"}, SEL_ST, 32'd0);
    push({tag, "_cycle"}, SEL_CYC, 32'd0);
    push({tag, "_instr"}, SEL_INS, 32'd0);
    push({tag, "_stall"}, SEL_STL, 32'd0);
    push({tag, "_flush"}, SEL_FLS, 32'd0);
    sample();
    n_run = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0;
    quiet();
    #2;
    push("rst_ctl", SEL_CTL, {25'd0, FREEZE});
    push("rst_state", SEL_ST, 32'd0);
    push("rst_cycle", SEL_CYC, 32'd0);
    push("rst_instr", SEL_INS, 32'd0);
    push("rst_stall", SEL_STL, 32'd0);
    push("rst_flush", SEL_FLS, 32'd0);
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1; rst2_n = 1'b1;
    cyc("idle", FREEZE, 2'd0);

    // Narrow-counter instance: 17 RUN cycles wrap a 4-bit cycle counter to 1.
    start2 = 1'b1;
    cyc("idle_start2", FREEZE, 2'd0);
    start2 = 1'b0;
    repeat (17) cyc("idle_wait", FREEZE, 2'd0);
    push("small_cycle_wrap", SEL_S_CYC, 32'd1);
    push("small_state", SEL_S_ST, 32'd1);
    push("small_ctl", SEL_S_CTL, 32'd0);
    push("small_counts", SEL_S_CNT, 32'd0);
    cyc("idle_after_small", FREEZE, 2'd0);

    start = 1'b1;
    cyc("start", FREEZE, 2'd0);
    start = 1'b0;

    E_icode = I_MRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
    push("lu_stall_pre", SEL_STL, 32'd0);
    cyc("lu", 7'b1101000, 2'd1);
    quiet();
    push("lu_stall_post", SEL_STL, 32'd1);
    cyc("after_lu", 7'b0000000, 2'd1);

    E_icode = I_JXX; e_Cnd = 1'b0;
    push("misp_flush_pre", SEL_FLS, 32'd0);
    cyc("misp", 7'b0011000, 2'd1);
    e_Cnd = 1'b1;
    push("misp_flush_post", SEL_FLS, 32'd1);
    cyc("jxx_taken", 7'b0000000, 2'd1);
    quiet();

    D_icode = I_RET;
    cyc("ret_D", 7'b1010000, 2'd1);
    D_icode = I_NOP; E_icode = I_RET;
    cyc("ret_E", 7'b1010000, 2'd1);
    E_icode = I_NOP; M_icode = I_RET;
    cyc("ret_M", 7'b1010000, 2'd1);
    quiet();

    D_icode = I_RET; E_icode = I_POPQ; E_dstM = 4'd4; d_srcB = 4'd4;
    cyc("lu_ret", 7'b1101000, 2'd1);
    quiet();
    E_icode = I_MRMOVQ;
    push("lu_none_stall", SEL_STL, 32'd2);
    push("lu_none_flush", SEL_FLS, 32'd1);
    cyc("lu_none", 7'b0000000, 2'd1);
    quiet();
    push("post_none_stall", SEL_STL, 32'd2);
    cyc("post_none", 7'b0000000, 2'd1);

    reset_mid("mid_rst");

    start = 1'b1;
    cyc("restart", FREEZE, 2'd0);
    start = 1'b0;
    E_icode = I_OPQ;
    for (int i = 0; i < 10; i++) begin
      W_icode = 4'(i + 2);
      cyc("retire", 7'b0000001, 2'd1);
    end
    quiet();
    W_icode = I_HALT; W_stat = STAT_HLT;
    push("halt_instr_pre", SEL_INS, 32'd10);
    cyc("halt_term", 7'b0000110, 2'd1);
    quiet();
    push("halted_instr", SEL_INS, 32'd10);
    cyc("halted", FREEZE, 2'd2);
    start = 1'b1;
    cyc("halt_start", FREEZE, 2'd2);
    start = 1'b0;
    push("halt_hold_instr", SEL_INS, 32'd10);
    cyc("halt_hold", FREEZE, 2'd2);

    reset_mid("rst2");
    start = 1'b1;
    cyc("start2", FREEZE, 2'd0);
    start = 1'b0;
    E_icode = I_OPQ; m_stat = STAT_ADR;
    cyc("exc_m", 7'b0000100, 2'd1);
    E_icode = I_NOP; m_stat = STAT_AOK; W_stat = STAT_ADR; W_icode = I_OPQ;
    push("fault_term_instr", SEL_INS, 32'd0);
    cyc("fault_term", 7'b0000110, 2'd1);
    quiet();
    cyc("fault", FREEZE, 2'd3);
    E_icode = I_MRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3; start = 1'b1;
    cyc("fault_lu", FREEZE, 2'd3);
    quiet(); start = 1'b0;
    push("fault_stall", SEL_STL, 32'd0);
    push("fault_instr", SEL_INS, 32'd0);
    cyc("fault_hold", FREEZE, 2'd3);

    reset_mid("rst3");
    start = 1'b1;
    cyc("start3", FREEZE, 2'd0);
    start = 1'b0;
    W_stat = STAT_INS;
    cyc("ins_term", 7'b0000110, 2'd1);
    quiet();
    cyc("ins_fault", FREEZE, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
